// File: rtl/kbd_pkg.sv
// Shared constants, event record and prefix-FSM state encoding for the PS/2 keyboard receiver.
package kbd_pkg;

  localparam logic [7:0] KBD_BRK        = 8'hF0;
  localparam logic [7:0] KBD_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  // "release" is a reserved word, so the break flag is carried as rel.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kbd_state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: input synchronisers, falling-edge sampling, format/parity check
// and mid-frame timeout recovery.
module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       frame_done,
  output logic [7:0] frame_byte,
  output logic       frame_err
);

  localparam int          TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]      clk_sync;
  logic [2:0]      dat_sync;
  logic [3:0]      bit_cnt;
  logic [9:0]      shift;
  logic [TO_W-1:0] idle_cnt;
  logic            fall;
  logic            bit_in;
  logic            frame_ok;

  // Stage 1 of the data synchroniser lines up with the clock sample that just went low.
  assign fall   = (clk_sync[2:1] == 2'b10);
  assign bit_in = dat_sync[1];

  assign frame_ok = (shift[0] == 1'b0) && (bit_in == 1'b1) &&
                    odd_parity_ok(shift[8:1], shift[9]);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 3'b111;
      dat_sync   <= 3'b111;
      bit_cnt    <= '0;
      shift      <= '0;
      idle_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_byte <= '0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      dat_sync   <= {dat_sync[1:0], ps2_data};
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            frame_done <= 1'b1;
            frame_byte <= shift[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift[bit_cnt] <= bit_in;
          bit_cnt        <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        // A stalled partial frame is abandoned so the next start bit realigns us.
        if (idle_cnt == TO_LAST) begin
          bit_cnt   <= '0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: E0/F0 prefix decoding, event FIFO with valid/ready drain,
// press counter and held-key tracking. Define PS2_REPEAT_FILTER_EN to drop typematic repeats.
module ps2_kbd_rx
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic [CNT_W-1:0] press_count,
  output logic             is_press,
  output logic             frame_err,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       frame_done;
  logic [7:0] frame_byte;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .frame_done (frame_done),
    .frame_byte (frame_byte),
    .frame_err  (frame_err)
  );

  kbd_state_t state_q, state_d;
  kbd_event_t ev;
  logic       ev_strobe;
  logic       is_repeat;
  logic       ev_wr;
  logic [8:0] held_key;

  always_comb begin
    state_d   = state_q;
    ev_strobe = 1'b0;
    ev        = '0;
    ev.code   = frame_byte;
    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_byte == KBD_EXT)      state_d = ST_EXT;
          else if (frame_byte == KBD_BRK) state_d = ST_BRK;
          else                            ev_strobe = 1'b1;
        end
        ST_EXT: begin
          if (frame_byte == KBD_BRK)      state_d = ST_EXT_BRK;
          else if (frame_byte != KBD_EXT) begin
            ev_strobe = 1'b1;
            ev.ext    = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_strobe = 1'b1;
          ev.rel    = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_EXT_BRK: begin
          ev_strobe = 1'b1;
          ev.ext    = 1'b1;
          ev.rel    = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  assign is_repeat = ev_strobe && !ev.rel && is_press && ({ev.ext, ev.code} == held_key);
`else
  assign is_repeat = 1'b0;
`endif
  assign ev_wr = ev_strobe && !is_repeat;

  kbd_event_t mem [FIFO_DEPTH];
  kbd_event_t head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && key_ready;
  // A pop in the same cycle frees the slot the write needs.
  assign push  = ev_wr && (!full || pop);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign key_valid   = !empty;
  assign key_code    = key_valid ? head.code : '0;
  assign key_ext     = key_valid ? head.ext  : 1'b0;
  assign key_release = key_valid ? head.rel  : 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      press_count <= '0;
      is_press    <= 1'b0;
      held_key    <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ev_wr && full && !pop) overflow <= 1'b1;
      // Key status follows every decoded event, whether or not the FIFO had room.
      if (ev_wr) begin
        if (!ev.rel) begin
          press_count <= press_count + 1'b1;
          held_key    <= {ev.ext, ev.code};
          is_press    <= 1'b1;
        end else if ({ev.ext, ev.code} == held_key) begin
          is_press <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard testbench for ps2_kbd_rx: bit-bangs PS/2 frames and checks drained events in order.
module tb_ps2_kbd_rx;
  localparam int FIFO_DEPTH  = 8;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 200;
  localparam int HALF        = 80;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic             key_valid;
  logic             key_ready = 1'b0;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic [CNT_W-1:0] press_count;
  logic             is_press;
  logic             frame_err;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int ev_seen = 0;
  int err_pulses = 0;
  logic [9:0] exp_q [$];

  ps2_kbd_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .press_count (press_count),
    .is_press    (is_press),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Every accepted head entry is compared against the oldest expected event.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      checks++;
      ev_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected got=%h expected=none", {key_ext, key_release, key_code});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({key_ext, key_release, key_code} !== e) begin
          errors++;
          $display("FAIL event_data got=%h expected=%h", {key_ext, key_release, key_code}, e);
        end
      end
    end
    if (!rst && frame_err === 1'b1) err_pulses++;
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
    end
    #(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({key_valid, key_code, key_ext, key_release, press_count, is_press, frame_err, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=0",
               {key_valid, key_code, key_ext, key_release, press_count, is_press, frame_err, overflow});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_make;
    key_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    fork
      send_byte(8'h1C, 1'b0);
      begin
        int n = 0;
        while (dut.frame_done !== 1'b1 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (n >= 2000) begin
          errors++;
          $display("FAIL single_frame_done timeout got=0 expected=1");
        end else begin
          if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass key_valid=%b expected=0", key_valid);
          end
          @(negedge clk);
          checks++;
          if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency key_valid=%b expected=1", key_valid);
          end
        end
      end
    join
    checks++;
    if (press_count !== 8'd1 || is_press !== 1'b1 || ev_seen != 1) begin
      errors++;
      $display("FAIL single_status count=%0d is_press=%b events=%0d expected 1 1 1",
               press_count, is_press, ev_seen);
    end
  endtask

  task automatic test_ext_release;
    int ev0 = ev_seen;
    exp_q.push_back({1'b1, 1'b1, 8'h75});
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    checks++;
    if (ev_seen != ev0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ext_release_count events=%0d expected=%0d pending=%0d", ev_seen - ev0, 1, exp_q.size());
    end
    checks++;
    if (press_count !== 8'd1 || is_press !== 1'b1) begin
      errors++;
      $display("FAIL ext_release_status count=%0d is_press=%b expected 1 1", press_count, is_press);
    end
  endtask

  task automatic test_bad_parity;
    int e0 = err_pulses;
    int ev0 = ev_seen;
    send_byte(8'h1C, 1'b1);
    checks++;
    if (err_pulses != e0 + 1) begin
      errors++;
      $display("FAIL parity_err_pulse got=%0d expected=1", err_pulses - e0);
    end
    checks++;
    if (ev_seen != ev0 || key_valid !== 1'b0 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL parity_no_event events=%0d valid=%b count=%0d expected 0 0 1",
               ev_seen - ev0, key_valid, press_count);
    end
  endtask

  task automatic test_overflow;
    int ev0 = ev_seen;
    int n = 0;
    key_ready = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back({2'b00, 8'(8'h15 + i)});
      send_byte(8'(8'h15 + i), 1'b0);
    end
    checks++;
    if (overflow !== 1'b1 || key_valid !== 1'b1 || press_count !== 8'(1 + FIFO_DEPTH + 1)) begin
      errors++;
      $display("FAIL overflow_state ovf=%b valid=%b count=%0d expected 1 1 %0d",
               overflow, key_valid, press_count, 1 + FIFO_DEPTH + 1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (key_code !== 8'h15 || key_ext !== 1'b0 || key_release !== 1'b0) begin
        errors++;
        $display("FAIL overflow_head_hold got=%h expected=015", {key_ext, key_release, key_code});
      end
    end
    key_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (ev_seen != ev0 + FIFO_DEPTH || key_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain events=%0d valid=%b ovf=%b expected %0d 0 1",
               ev_seen - ev0, key_valid, overflow, FIFO_DEPTH);
    end
  endtask

  task automatic test_repeat;
    logic [CNT_W-1:0] pc;
    int makes;
    pc = press_count;
`ifdef PS2_REPEAT_FILTER_EN
    makes = 1;
`else
    makes = 3;
`endif
    for (int i = 0; i < makes; i++) exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b01, 8'h1C});
    for (int i = 0; i < 3; i++) send_byte(8'h1C, 1'b0);
    checks++;
    if (press_count !== 8'(pc + makes) || is_press !== 1'b1) begin
      errors++;
      $display("FAIL repeat_count count=%0d is_press=%b expected %0d 1", press_count, is_press, pc + makes);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    checks++;
    if (is_press !== 1'b0 || exp_q.size() != 0 || press_count !== 8'(pc + makes)) begin
      errors++;
      $display("FAIL repeat_release is_press=%b pending=%0d count=%0d expected 0 0 %0d",
               is_press, exp_q.size(), press_count, pc + makes);
    end
  endtask

  task automatic test_timeout;
    int e0 = err_pulses;
    int ev0 = ev_seen;
    logic [CNT_W-1:0] pc;
    pc = press_count;
    send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 5);
    repeat (TIMEOUT_CYC + 40) @(posedge clk);
    checks++;
    if (err_pulses != e0 + 1 || ev_seen != ev0) begin
      errors++;
      $display("FAIL timeout_err pulses=%0d events=%0d expected 1 0", err_pulses - e0, ev_seen - ev0);
    end
    exp_q.push_back({2'b00, 8'h32});
    send_byte(8'h32, 1'b0);
    checks++;
    if (exp_q.size() != 0 || ev_seen != ev0 + 1 || press_count !== 8'(pc + 1) ||
        is_press !== 1'b1 || err_pulses != e0 + 1) begin
      errors++;
      $display("FAIL timeout_recover pending=%0d events=%0d count=%0d is_press=%b expected 0 1 %0d 1",
               exp_q.size(), ev_seen - ev0, press_count, is_press, pc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_ext_release();
    test_bad_parity();
    test_overflow();
    test_repeat();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
